// File: rtl/inv_subword_seq.sv
// Byte-serial AES inverse S-box engine: one InvSubBytes byte per cycle over a
// captured word. The field inversion runs in the tower GF(((2^2)^2)^2). The
// basis-change matrices to and from that tower are derived at elaboration
// from a root of the AES reduction polynomial.
module inv_subword_seq #(
  parameter int unsigned NUM_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*NUM_BYTES-1:0] in_word,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*NUM_BYTES-1:0] out_word,
  output logic                   busy
);

  localparam int unsigned CNT_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BYTES - 1);
  // z^2 = z + LAMBDA over GF(16); LAMBDA = w*y has absolute trace 1
  localparam logic [3:0] LAMBDA = 4'b1000;

  typedef enum logic [1:0] {IDLE = 2'd0, PROC = 2'd1, DONE = 2'd2} state_t;

  // GF(4) with w^2 = w + 1, element {a1,a0} = a1*w + a0
  function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
    return {(a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]), (a[1] & b[1]) ^ (a[0] & b[0])};
  endfunction

  // In GF(4) the inverse is the square; zero stays zero
  function automatic logic [1:0] gf4_inv(input logic [1:0] a);
    return {a[1], a[1] ^ a[0]};
  endfunction

  // Multiply by N = w, the GF(16) extension constant
  function automatic logic [1:0] gf4_mul_n(input logic [1:0] a);
    return {a[1] ^ a[0], a[1]};
  endfunction

  // GF(16) = GF(4)[y], y^2 = y + N
  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [1:0] hh;
    hh = gf4_mul(a[3:2], b[3:2]);
    return {hh ^ gf4_mul(a[3:2], b[1:0]) ^ gf4_mul(a[1:0], b[3:2]),
            gf4_mul_n(hh) ^ gf4_mul(a[1:0], b[1:0])};
  endfunction

  // GF(16) subfield inversion via the GF(4) norm
  function automatic logic [3:0] gf16_inv(input logic [3:0] a);
    logic [1:0] d, di;
    d  = gf4_mul_n(gf4_mul(a[3:2], a[3:2])) ^ gf4_mul(a[3:2], a[1:0]) ^ gf4_mul(a[1:0], a[1:0]);
    di = gf4_inv(d);
    return {gf4_mul(a[3:2], di), gf4_mul(a[3:2] ^ a[1:0], di)};
  endfunction

  // GF(256) = GF(16)[z], z^2 = z + LAMBDA
  function automatic logic [7:0] gf256_mul(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] hh;
    hh = gf16_mul(a[7:4], b[7:4]);
    return {hh ^ gf16_mul(a[7:4], b[3:0]) ^ gf16_mul(a[3:0], b[7:4]),
            gf16_mul(hh, LAMBDA) ^ gf16_mul(a[3:0], b[3:0])};
  endfunction

  // Tower-field inversion via the GF(16) norm; zero maps to zero
  function automatic logic [7:0] gf256_inv(input logic [7:0] a);
    logic [3:0] d, di;
    d  = gf16_mul(gf16_mul(a[7:4], a[7:4]), LAMBDA) ^ gf16_mul(a[7:4], a[3:0])
       ^ gf16_mul(a[3:0], a[3:0]);
    di = gf16_inv(d);
    return {gf16_mul(a[7:4], di), gf16_mul(a[7:4] ^ a[3:0], di)};
  endfunction

  // Linear map: column i (bits 8i+7:8i) is the image of input bit i
  function automatic logic [7:0] gf_map(input logic [63:0] m, input logic [7:0] x);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (x[i]) acc ^= m[8*i +: 8];
    end
    return acc;
  endfunction

  // AES basis -> tower basis: x maps to a tower root r of x^8+x^4+x^3+x+1
  function automatic logic [63:0] build_a2t();
    logic [7:0]  root, pw, acc;
    logic [63:0] m;
    root = 8'h00;
    m    = '0;
    for (int c = 2; c < 256; c++) begin
      pw  = 8'h01;
      acc = 8'h01;
      for (int i = 1; i <= 8; i++) begin
        pw = gf256_mul(pw, 8'(c));
        if (i == 1 || i == 3 || i == 4 || i == 8) acc ^= pw;
      end
      if (acc == 8'h00 && root == 8'h00) root = 8'(c);
    end
    pw = 8'h01;
    for (int i = 0; i < 8; i++) begin
      m[8*i +: 8] = pw;
      pw = gf256_mul(pw, root);
    end
    return m;
  endfunction

  // Tower basis -> AES basis: inverse of the forward map, found column by column
  function automatic logic [63:0] build_t2a(input logic [63:0] a2t);
    logic [63:0] m;
    m = '0;
    for (int j = 0; j < 8; j++) begin
      for (int c = 0; c < 256; c++) begin
        if (gf_map(a2t, 8'(c)) == 8'(1 << j)) m[8*j +: 8] = 8'(c);
      end
    end
    return m;
  endfunction

  localparam logic [63:0] A2T = build_a2t();
  localparam logic [63:0] T2A = build_t2a(A2T);

  // Inverse affine: b = rotl(s,1) ^ rotl(s,3) ^ rotl(s,6) ^ 0x05
  function automatic logic [7:0] inv_affine(input logic [7:0] s);
    return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return gf_map(T2A, gf256_inv(gf_map(A2T, inv_affine(b))));
  endfunction

  state_t                       state, state_nxt;
  logic [CNT_W-1:0]             cnt;
  logic [NUM_BYTES-1:0][7:0]    in_q;
  logic [NUM_BYTES-1:0][7:0]    out_q;
  logic                         accept;
  logic [7:0]                   byte_in, byte_out;

  assign out_word = out_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = PROC;
      PROC:    if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = accept ? PROC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs; in_ready is held low while reset is asserted
  always_comb begin
    in_ready = 1'b0;
    if (!reset) in_ready = (state == IDLE) || (state == DONE && out_ready);
    accept = in_valid && in_ready;
  end

  // Combinational inverse S-box on the byte selected by cnt
  always_comb begin
    byte_in  = in_q[cnt];
    byte_out = inv_sbox(byte_in);
  end

  // Word capture, byte write-back and byte counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_q  <= '0;
      out_q <= '0;
      cnt   <= '0;
    end else if (accept) begin
      in_q <= in_word;
      cnt  <= '0;
    end else if (state == PROC) begin
      out_q[cnt] <= byte_out;
      cnt        <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

  // Registered status flags decoded from the upcoming state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      out_valid <= (state_nxt == DONE);
      busy      <= (state_nxt == PROC);
    end
  end

endmodule

// File: tb/tb_inv_subword_seq.sv
// Self-checking bench for inv_subword_seq: fixed vectors, handshake corner
// cases and randomized words against a polynomial-basis InvSBox model.
module tb_inv_subword_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_word = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_word;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] inv_tab [256];

  inv_subword_seq #(.NUM_BYTES(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_word(in_word), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (xmul(a, 8'(y)) == 8'h01) r = 8'(y);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
    logic [15:0] d;
    d = {v, v} << k;
    return d[15:8];
  endfunction

  // Forward S-box: inverse, then affine; InvSBox is its inverse permutation
  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] w);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = inv_tab[w[8*k +: 8]];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Present a word until accepted; called and returns 1 time unit after a rising edge
  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_word  = w;
    #1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    chk("accept_wait", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait for out_valid counting edges and busy samples, then complete the handshake
  task automatic recv(output logic [31:0] w, output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    out_ready = 1'b1;
    while (!out_valid && lat < 50) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    w = out_word;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  initial begin
    vec_t        vecs [6];
    logic [31:0] w, w2, hold;
    logic [7:0]  perm [256];
    logic [7:0]  tmp;
    int          lat, bcnt, j, st;
    bit          bad_v, bad_w, bad_r, pulse;

    for (int x = 0; x < 256; x++) inv_tab[fwd_sbox(8'(x))] = 8'(x);

    vecs[0] = '{32'h637C7716, 32'h000102FF};
    vecs[1] = '{32'h00000000, 32'h52525252};
    vecs[2] = '{32'hFFFFFFFF, 32'h7D7D7D7D};
    vecs[3] = '{32'h03020100, 32'hD56A0952};
    vecs[4] = '{32'h52525252, 32'h48484848};
    vecs[5] = '{32'h63636363, 32'h00000000};

    // Asynchronous reset asserted mid-cycle
    #3 reset = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #4 reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_out_word", out_word, 32'h0);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Fixed vectors with latency and busy-duration checks
    for (int i = 0; i < 6; i++) begin
      out_ready = 1'b1;
      send(vecs[i].din);
      recv(w, lat, bcnt);
      chk($sformatf("vec%0d_word", i), w, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      chk($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'd4);
      chk($sformatf("vec%0d_valid_drop", i), 32'(out_valid), 32'd0);
      chk($sformatf("vec%0d_word_hold", i), out_word, vecs[i].exp);
    end

    // Backpressure: result held for 10 cycles, then back-to-back accept on handshake
    out_ready = 1'b0;
    w = 32'hDEADBEEF;
    send(w);
    j = 0;
    while (!out_valid && j < 50) begin @(posedge clk); #1; j++; end
    chk("bp_valid_rise", 32'(j), 32'd4);
    hold  = out_word;
    bad_v = 1'b0; bad_w = 1'b0; bad_r = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (!out_valid) bad_v = 1'b1;
      if (out_word !== hold) bad_w = 1'b1;
      if (in_ready) bad_r = 1'b1;
    end
    chk("bp_word", hold, ref_word(w));
    chk("bp_valid_held", 32'(bad_v), 32'd0);
    chk("bp_word_stable", 32'(bad_w), 32'd0);
    chk("bp_in_ready_low", 32'(bad_r), 32'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_on_out_ready", 32'(in_ready), 32'd1);
    w2 = 32'h0BADF00D;
    send(w2);
    chk("bp_b2b_out_valid", 32'(out_valid), 32'd0);
    chk("bp_b2b_busy", 32'(busy), 32'd1);
    recv(w, lat, bcnt);
    chk("bp_b2b_word", w, ref_word(w2));
    chk("bp_b2b_latency", 32'(lat), 32'd4);

    // Reset while processing byte 2: no pulse, engine restarts cleanly
    send(32'h12345678);
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #4 reset = 1'b0;
    pulse = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) pulse = 1'b1;
    end
    chk("mid_rst_no_pulse", 32'(pulse), 32'd0);
    send(32'h52525252);
    recv(w, lat, bcnt);
    chk("mid_rst_next_word", w, 32'h48484848);
    chk("mid_rst_next_latency", 32'(lat), 32'd4);

    // in_valid during PROC must be ignored
    w2 = 32'hA1B2C3D4;
    send(w2);
    in_valid = 1'b1;
    in_word  = 32'hFFFFFFFF;
    #1;
    chk("ign_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_word  = '0;
    recv(w, lat, bcnt);
    chk("ign_word", w, ref_word(w2));
    chk("ign_idle_after", 32'(busy), 32'd0);

    // All 256 byte values in shuffled order, 64 words, random output stalls
    for (int i = 0; i < 256; i++) perm[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    for (int i = 0; i < 64; i++) begin
      w = {perm[4*i+3], perm[4*i+2], perm[4*i+1], perm[4*i]};
      out_ready = 1'b0;
      send(w);
      st = int'($urandom_range(6, 0));
      repeat (st) begin @(posedge clk); #1; end
      recv(w2, lat, bcnt);
      chk($sformatf("exh%0d_word_%h", i, w), w2, ref_word(w));
    end

    // Fully random words
    for (int i = 0; i < 20; i++) begin
      w = $urandom;
      out_ready = 1'b1;
      send(w);
      recv(w2, lat, bcnt);
      chk($sformatf("rnd%0d_word_%h", i, w), w2, ref_word(w));
      chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'd4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
